// File: rtl/snn_interfaces_pkg.sv
// Shared types and helpers for the packed-coordinate spike interface.
package snn_interfaces_pkg;

   localparam int DEFAULT_COORD_BITS = 8;
   localparam int DEFAULT_CHANNELS   = 6;
   localparam int DEFAULT_CH_BITS    = (DEFAULT_CHANNELS > 1) ? $clog2(DEFAULT_CHANNELS) : 1;

   typedef struct packed {
      logic [DEFAULT_COORD_BITS-1:0] x;
      logic [DEFAULT_COORD_BITS-1:0] y;
   } vec2_t;

   typedef struct packed {
      logic [DEFAULT_CH_BITS-1:0] ch;
      vec2_t                      coord;
   } spike_event_t;

   // x lands in the upper half of the packed word, y in the lower half.
   function automatic vec2_t pack_coordinates(input logic [DEFAULT_COORD_BITS-1:0] x,
                                              input logic [DEFAULT_COORD_BITS-1:0] y);
      vec2_t v;
      v.x = x;
      v.y = y;
      return v;
   endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit finder: index of the lowest 1 plus an any flag.
module lsb_priority_encoder #(
   parameter  int WIDTH = 32,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_W'(i);
      end
   end

   assign any = |vec;

endmodule

// File: rtl/spike_event_encoder.sv
// Serialises one row of spikes per transaction into per-spike {x,y}/channel events.
// Optional SPIKE_ENC_STATS_EN adds a saturating per-frame event counter (ev_count).
//
// state  | meaning
// IDLE   | row_ready high, waiting for a row
// SCAN   | emitting one event per handshake, lowest remaining x first
module spike_event_encoder
   import snn_interfaces_pkg::*;
#(
   parameter  int COORD_BITS = 8,
   parameter  int IMG_WIDTH  = 32,
   parameter  int IMG_HEIGHT = 32,
   parameter  int CHANNELS   = 6,
   localparam int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    row_valid,
   output logic                    row_ready,
   input  logic [IMG_WIDTH-1:0]    row_spikes,
   input  logic [COORD_BITS-1:0]   row_y,
   input  logic [CH_BITS-1:0]      row_ch,
   input  logic                    row_last,
   output logic                    ev_valid,
   input  logic                    ev_ready,
   output logic [2*COORD_BITS-1:0] ev_coord,
   output logic [CH_BITS-1:0]      ev_ch,
   output logic                    frame_done,
   output logic                    err_sticky
`ifdef SPIKE_ENC_STATS_EN
   ,
   output logic [31:0]             ev_count
`endif
);

   localparam int X_BITS = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [COORD_BITS:0] HEIGHT_LIM = (COORD_BITS + 1)'(IMG_HEIGHT);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SCAN = 1'b1;

   if (IMG_WIDTH > 2 ** COORD_BITS) begin : g_width_check
      $error("IMG_WIDTH exceeds the range of one coordinate");
   end

   logic [0:0]            state_q, state_d;
   logic [IMG_WIDTH-1:0]  rem_q, rem_d;
   logic [COORD_BITS-1:0] y_q, y_d;
   logic [CH_BITS-1:0]    ch_q, ch_d;
   logic                  last_q, last_d;
   logic                  err_q, err_d;
   logic                  fd_q, fd_d;
   logic                  rdy_q;

   logic [X_BITS-1:0]       pe_idx;
   logic                    pe_any;
   logic [COORD_BITS-1:0]   x_min;
   logic [IMG_WIDTH-1:0]    rem_next;
   logic [2*COORD_BITS-1:0] coord_w;
   logic                    last_hs;

   lsb_priority_encoder #(.WIDTH(IMG_WIDTH)) u_pe (
      .vec (rem_q),
      .idx (pe_idx),
      .any (pe_any)
   );

   assign x_min = COORD_BITS'(pe_idx);

   if (COORD_BITS == DEFAULT_COORD_BITS) begin : g_pkg_pack
      vec2_t packed_c;
      assign packed_c = pack_coordinates(x_min, y_q);
      assign coord_w  = packed_c;
   end else begin : g_wide_pack
      assign coord_w = {x_min, y_q};
   end

   // Clearing the lowest set bit; matches the bit the encoder points at.
   assign rem_next = rem_q & (rem_q - IMG_WIDTH'(1));

   assign row_ready  = rdy_q && (state_q == S_IDLE);
   assign ev_valid   = (state_q == S_SCAN) && pe_any;
   assign ev_coord   = ev_valid ? coord_w : '0;
   assign ev_ch      = ev_valid ? ch_q : '0;
   assign last_hs    = ev_valid && ev_ready && (rem_next == '0);
   assign frame_done = fd_q || (last_hs && last_q);
   assign err_sticky = err_q;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      y_d     = y_q;
      ch_d    = ch_q;
      last_d  = last_q;
      err_d   = err_q;
      fd_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (row_valid && row_ready) begin
               y_d    = row_y;
               ch_d   = row_ch;
               last_d = row_last;
               if ({1'b0, row_y} >= HEIGHT_LIM) begin
                  err_d = 1'b1;
                  fd_d  = row_last;
                  rem_d = '0;
               end else if (row_spikes == '0) begin
                  fd_d  = row_last;
                  rem_d = '0;
               end else begin
                  rem_d   = row_spikes;
                  state_d = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            if (ev_valid && ev_ready) begin
               rem_d = rem_next;
               if (rem_next == '0) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         y_q     <= '0;
         ch_q    <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         fd_q    <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         last_q  <= last_d;
         err_q   <= err_d;
         fd_q    <= fd_d;
         rdy_q   <= 1'b1;
      end
   end

`ifdef SPIKE_ENC_STATS_EN
   logic [31:0] cnt_q, cnt_d;

   // The count seen during a frame_done cycle is held for that cycle, then cleared.
   always_comb begin
      cnt_d = cnt_q;
      if (frame_done) cnt_d = '0;
      else if (ev_valid && ev_ready && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign ev_count = cnt_q;
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Self-checking bench for spike_event_encoder against a row-to-event-list model.
module tb_spike_event_encoder;

   localparam int CB  = 8;
   localparam int W   = 32;
   localparam int H   = 32;
   localparam int CHB = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            row_valid = 1'b0;
   logic            row_ready;
   logic [W-1:0]    row_spikes = '0;
   logic [CB-1:0]   row_y = '0;
   logic [CHB-1:0]  row_ch = '0;
   logic            row_last = 1'b0;
   logic            ev_valid;
   logic            ev_ready = 1'b0;
   logic [2*CB-1:0] ev_coord;
   logic [CHB-1:0]  ev_ch;
   logic            frame_done;
   logic            err_sticky;
`ifdef SPIKE_ENC_STATS_EN
   logic [31:0]     ev_count;
`endif

   spike_event_encoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .row_valid  (row_valid),
      .row_ready  (row_ready),
      .row_spikes (row_spikes),
      .row_y      (row_y),
      .row_ch     (row_ch),
      .row_last   (row_last),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_coord   (ev_coord),
      .ev_ch      (ev_ch),
      .frame_done (frame_done),
      .err_sticky (err_sticky)
`ifdef SPIKE_ENC_STATS_EN
      ,
      .ev_count   (ev_count)
`endif
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   bit          err_exp = 1'b0;
   int unsigned exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: every set bit x of a legal row becomes one event x*2^CB + y, ascending x.
   function automatic void build_expected(input logic [W-1:0] spikes, input int y);
      exp_q.delete();
      if (y < H) begin
         for (int x = 0; x < W; x++) begin
            if (spikes[x]) exp_q.push_back(x * (2 ** CB) + y);
         end
      end
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      row_valid = 1'b0;
      ev_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_row_ready", row_ready, 0);
      check("rst_ev_valid", ev_valid, 0);
      check("rst_ev_coord", ev_coord, 0);
      check("rst_ev_ch", ev_ch, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_err", err_sticky, 0);
      err_exp = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rel_row_ready", row_ready, 1);
`ifdef SPIKE_ENC_STATS_EN
      check("rel_ev_count", ev_count, 0);
`endif
   endtask

   // Caller is at posedge+1; returns at posedge+1 of the first cycle after acceptance.
   task automatic send_row(input logic [W-1:0] spikes, input int y, input int ch, input bit last);
      int t = 0;
      while (!row_ready && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("row_ready_wait", row_ready, 1);
      row_valid  = 1'b1;
      row_spikes = spikes;
      row_y      = CB'(y);
      row_ch     = CHB'(ch);
      row_last   = last;
      @(posedge clk);
      #1;
      row_valid = 1'b0;
      if (y >= H) err_exp = 1'b1;
      build_expected(spikes, y);
      check("err_sticky", err_sticky, err_exp);
      if (exp_q.size() == 0) begin
         check("empty_ev_valid", ev_valid, 0);
         check("empty_frame_done", frame_done, last);
         check("empty_row_ready", row_ready, 1);
         @(posedge clk);
         #1;
         check("empty_fd_once", frame_done, 0);
         check("empty_ev_valid2", ev_valid, 0);
      end
   endtask

   // mode 0: ready always; 1: ready low for the first 4 cycles; 2: random ready.
   task automatic drain(input int ch, input bit last, input int mode, input int stop_after);
      int cyc = 0;
      int got = 0;
      bit exp_fd;
      while (exp_q.size() > 0 && got < stop_after && cyc < 400) begin
         case (mode)
            0:       ev_ready = 1'b1;
            1:       ev_ready = (cyc >= 4);
            default: ev_ready = ($urandom_range(0, 99) < 60);
         endcase
         #1;
         check("ev_valid", ev_valid, 1);
         check("ev_coord", ev_coord, exp_q[0]);
         check("ev_ch", ev_ch, ch);
         check("scan_row_ready", row_ready, 0);
         exp_fd = ev_ready && (exp_q.size() == 1) && last;
         check("scan_frame_done", frame_done, exp_fd);
         if (ev_ready) begin
            void'(exp_q.pop_front());
            got++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 400) check("drain_timeout", 1, 0);
      if (exp_q.size() == 0) begin
         check("post_ev_valid", ev_valid, 0);
         check("post_row_ready", row_ready, 1);
         check("post_frame_done", frame_done, 0);
         ev_ready = 1'b0;
      end
   endtask

   initial begin
      logic [W-1:0] sp;
      int           y;
      int           ch;
      bit           last;

      do_reset();

      send_row(32'h0000_0091, 5, 2, 1'b0);
      drain(2, 1'b0, 0, 1000);

      send_row(32'h0000_0091, 5, 2, 1'b0);
      drain(2, 1'b0, 1, 1000);

      send_row(32'h0000_0000, 9, 1, 1'b1);

      send_row(32'hFFFF_FFFF, 31, 3, 1'b1);
      drain(3, 1'b1, 0, 1000);

      send_row(32'h0000_00F0, 32, 0, 1'b0);
      send_row(32'h8000_0001, 0, 5, 1'b1);
      drain(5, 1'b1, 2, 1000);
      check("err_held", err_sticky, 1);

      for (int r = 0; r < 30; r++) begin
         case ($urandom_range(0, 3))
            0:       sp = '0;
            1:       sp = $urandom() & $urandom() & $urandom();
            default: sp = $urandom();
         endcase
         y    = $urandom_range(0, 35);
         ch   = $urandom_range(0, 5);
         last = 1'($urandom_range(0, 1));
         send_row(sp, y, ch, last);
         drain(ch, last, $urandom_range(0, 2), 1000);
      end

      send_row(32'h0000_001F, 3, 1, 1'b1);
      drain(1, 1'b1, 0, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_ev_valid", ev_valid, 0);
      check("midrst_row_ready", row_ready, 0);
      check("midrst_frame_done", frame_done, 0);
      check("midrst_err", err_sticky, 0);
      do_reset();
      send_row(32'h0000_0300, 7, 4, 1'b0);
      drain(4, 1'b0, 0, 1000);
      check("after_rst_err", err_sticky, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
